matrix_bank: RTL and testbench
==============================

# matrix_bank

Multi-slot matrix register bank for the matrix calculator datapath. It stores `SLOTS` matrices of `ROWS`×`COLS` elements, each `EW` bits wide. A matrix is written either in one cycle as a whole or streamed in row by row through a valid/ready handshake. A streamed matrix is staged internally and committed atomically, so a slot never holds a half-written matrix. One registered read port serves the arithmetic units, with an optional transposed read.

## Interface
Parameters:
- `EW`, 32, element width in bits
- `ROWS`, 4, rows per matrix
- `COLS`, 4, columns per matrix
- `SLOTS`, 4, number of stored matrices (≥2)
- Derived localparams: `MW = EW*ROWS*COLS`, `RW = EW*COLS`, `SW = max(1,$clog2(SLOTS))`

Ports:
- `CLK`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_op`  in  2  command: 0 NOP, 1 LOAD, 2 ROWLOAD, 3 CLEAR
- `cmd_slot`  in  SW  target slot
- `Min`  in  MW  full matrix for LOAD
- `row_valid`  in  1  row beat offered
- `row_ready`  out  1  row beat accepted when `row_valid & row_ready`
- `row_in`  in  RW  one row; element c is at `[c*EW +: EW]`
- `rd_slot`  in  SW  read slot select
- `rd_trans`  in  1  transposed read request (see Configuration)
- `matrix`  out  MW  registered read data
- `busy`  out  1  high while in STREAM
- `done`  out  1  one-cycle pulse when a command completes
- `err`  out  1  one-cycle pulse, coincident with `done`, when the target slot is out of range

## Operation
- Packing: element (r,c) occupies `[(r*COLS+c)*EW +: EW]`; row r occupies `[r*RW +: RW]`.
- The FSM has two states, IDLE and STREAM.
- IDLE:
  - `cmd_ready=1`, `row_ready=0`, `busy=0`.
  - NOP: no storage change; `done` pulses.
  - LOAD: `slot[cmd_slot] <= Min`; `done` pulses.
  - CLEAR: `slot[cmd_slot] <= 0`; `done` pulses.
  - ROWLOAD: latch `cmd_slot`, clear the row counter to 0, go to STREAM. `done` does not pulse yet.
- STREAM:
  - `cmd_ready=0`, `row_ready=1`, `busy=1`.
  - Each accepted beat writes `row_in` into staging row `cnt`, then `cnt++`.
  - On the beat with `cnt==ROWS-1`: commit `slot[latched] <= staging` with that final row merged in, clear the staging buffer, return to IDLE, pulse `done`.
  - `cmd_valid` is ignored in STREAM. Cycles with `row_valid=0` are stalls with no state change.
  - `row_valid` in IDLE is ignored.
- Out-of-range slot (`cmd_slot ≥ SLOTS`):
  - The command is accepted and nothing is written.
  - `done` and `err` pulse together. For ROWLOAD this happens immediately and the FSM stays in IDLE.
- Read path:
  - `matrix <= slot[rd_slot]` every cycle (transposed if enabled and requested).
  - If `rd_slot ≥ SLOTS`, `matrix <= 0`.
- Reset (asynchronous, any state, including mid-stream):
  - All slots, the staging buffer and `matrix` go to 0; `cnt` goes to 0; FSM goes to IDLE.
  - `done=0`, `err=0`, `busy=0`, `row_ready=0`, `cmd_ready=1` once reset is released.
  - A partially streamed matrix is discarded.

## Timing
- Commands: a command accepted at edge k updates storage at edge k. `done`/`err` are registered and high during cycle k→k+1.
- ROWLOAD:
  - The command at edge k0 enters STREAM.
  - With continuous beats, rows land at edges k0+1 … k0+ROWS, and the commit happens at edge k0+ROWS.
  - `done` is high in the following cycle. Minimum turnaround is ROWS+1 cycles per matrix.
- Read latency: 1 cycle from `rd_slot` to `matrix`.
- Read-during-write to the same slot at edge k:
  - `matrix` sampled at edge k returns the old contents.
  - The new contents appear when `matrix` is sampled at edge k+1.
- `cmd_ready`, `row_ready` and `busy` are decoded from the FSM state register (no combinational path from inputs).

## Configuration
- Macro: `MATRIX_BANK_TRANSPOSE_EN`.
- Defined:
  - With `rd_trans=1`, `matrix` element (c,r) is driven at the (c*ROWS+r) position, i.e. a COLS×ROWS packing of the stored matrix.
  - The transpose is applied in the same register stage, so latency is unchanged.
- Undefined:
  - `rd_trans` is ignored and no transpose mux is built. Output is always the straight packing.

## Test plan
- Reset then LOAD: assert and release `reset`, LOAD slot 2 with `Min[k*32+:32]=k` for k=0..15, read slot 2 → `matrix` element k = k one cycle later, `done` pulses once; slots 0, 1 and 3 read 0.
- ROWLOAD with stalls: ROWLOAD slot 1, send rows `{0x10+c}`, `{0x20+c}`, `{0x30+c}`, `{0x40+c}` with one idle cycle between beats. Slot 1 must read its old value until the 4th beat, then read element (r,c)=0x10*(r+1)+c. `done` pulses exactly once; `busy` is high from the command until the commit.
- Reset mid-stream: ROWLOAD slot 0, send 2 rows, pulse `reset` → slot 0 = 0, `busy=0`, `cmd_ready=1`. A following LOAD succeeds.
- Out-of-range slot with SLOTS=3: issue `cmd_slot=3` LOAD → `done` and `err` pulse together and no slot changes; `rd_slot=3` → `matrix=0`.
- Read-during-write: LOAD slot 0 with all 0xAAAAAAAA while `rd_slot=0`, then CLEAR slot 0 with `rd_slot=0` held. `matrix` shows 0xAA.. one cycle after the LOAD edge, then 0 one cycle after the CLEAR edge.
- Transpose (macro defined): slot holds element (r,c)=4r+c; with `rd_trans=1` → output element (c,r) position holds 4r+c. With the macro undefined, the same stimulus returns the straight packing.

Source files
------------

// File: rtl/matrix_bank.sv
// matrix_bank: SLOTS-deep bank of ROWS x COLS matrices with whole-matrix LOAD, row-streamed ROWLOAD and one registered read port.
// Define MATRIX_BANK_TRANSPOSE_EN to build the transposed read path selected by rd_trans.
module matrix_bank #(
    parameter int EW    = 32,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int SLOTS = 4,
    localparam int MW   = EW * ROWS * COLS,
    localparam int RW   = EW * COLS,
    localparam int SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [SW-1:0] cmd_slot,
    input  logic [MW-1:0] Min,
    input  logic          row_valid,
    output logic          row_ready,
    input  logic [RW-1:0] row_in,
    input  logic [SW-1:0] rd_slot,
    input  logic          rd_trans,
    output logic [MW-1:0] matrix,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [SW:0]   SLOT_LIMIT = (SW+1)'(SLOTS);
    localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS - 1);

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_ROWLOAD = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_slotSel;
    logic [MW-1:0] r_stage;
    logic [MW-1:0] r_slots [SLOTS];
    logic [MW-1:0] r_matrix;
    logic          r_done;
    logic          r_err;

    logic          w_cmdFire;
    logic          w_rowFire;
    logic          w_cmdInRange;
    logic          w_lastBeat;
    logic [MW-1:0] w_stageMerged;
    logic [MW-1:0] w_rdData;
    logic [MW-1:0] w_rdView;

    assign cmd_ready = (r_state == ST_IDLE);
    assign row_ready = (r_state == ST_STREAM);
    assign busy      = (r_state == ST_STREAM);
    assign matrix    = r_matrix;
    assign done      = r_done;
    assign err       = r_err;

    assign w_cmdFire    = cmd_valid && (r_state == ST_IDLE);
    assign w_rowFire    = row_valid && (r_state == ST_STREAM);
    assign w_cmdInRange = ({1'b0, cmd_slot} < SLOT_LIMIT);
    assign w_lastBeat   = (r_cnt == LAST_ROW);

    // The final beat is merged combinationally so the commit carries all rows in the same edge.
    always_comb begin
        w_stageMerged = r_stage;
        w_stageMerged[r_cnt*RW +: RW] = row_in;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_slotSel <= '0;
            r_stage   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmdFire) begin
                        r_done <= (cmd_op != OP_ROWLOAD) || !w_cmdInRange;
                        r_err  <= (cmd_op != OP_NOP) && !w_cmdInRange;
                        if ((cmd_op == OP_ROWLOAD) && w_cmdInRange) begin
                            r_state   <= ST_STREAM;
                            r_slotSel <= cmd_slot;
                            r_cnt     <= '0;
                            r_stage   <= '0;
                        end
                    end
                end
                default: begin
                    if (w_rowFire) begin
                        if (w_lastBeat) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_stage <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stage <= w_stageMerged;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Command writes and stream commits never coincide because they are gated by different states.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SLOTS; s++) begin
                r_slots[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_cmdFire && w_cmdInRange && (cmd_slot == SW'(s))) begin
                    if (cmd_op == OP_LOAD) begin
                        r_slots[s] <= Min;
                    end else if (cmd_op == OP_CLEAR) begin
                        r_slots[s] <= '0;
                    end
                end else if (w_rowFire && w_lastBeat && (r_slotSel == SW'(s))) begin
                    r_slots[s] <= w_stageMerged;
                end
            end
        end
    end

    always_comb begin
        w_rdData = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (rd_slot == SW'(s)) begin
                w_rdData = r_slots[s];
            end
        end
    end

`ifdef MATRIX_BANK_TRANSPOSE_EN
    always_comb begin
        w_rdView = w_rdData;
        if (rd_trans) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    w_rdView[(c*ROWS + r)*EW +: EW] = w_rdData[(r*COLS + c)*EW +: EW];
                end
            end
        end
    end
`else
    logic w_unusedTrans;
    assign w_unusedTrans = rd_trans;
    assign w_rdView      = w_rdData;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_matrix <= '0;
        end else begin
            r_matrix <= w_rdView;
        end
    end

endmodule

// File: tb/tb_matrix_bank.sv
// tb_matrix_bank: randomized scoreboard bench for matrix_bank (SLOTS=3 so slot 3 is out of range).
// Honors MATRIX_BANK_TRANSPOSE_EN in its reference model.
module tb_matrix_bank;

    localparam int EW    = 32;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SLOTS = 3;
    localparam int MW    = EW * ROWS * COLS;
    localparam int RW    = EW * COLS;
    localparam int SW    = 2;

`ifdef MATRIX_BANK_TRANSPOSE_EN
    localparam bit TRANSPOSE = 1'b1;
`else
    localparam bit TRANSPOSE = 1'b0;
`endif

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_ROWLOAD = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [SW-1:0] cmd_slot = '0;
    logic [MW-1:0] Min = '0;
    logic          row_valid = 1'b0;
    logic          row_ready;
    logic [RW-1:0] row_in = '0;
    logic [SW-1:0] rd_slot = '0;
    logic          rd_trans = 1'b0;
    logic [MW-1:0] matrix;
    logic          busy;
    logic          done;
    logic          err;

    matrix_bank #(
        .EW(EW), .ROWS(ROWS), .COLS(COLS), .SLOTS(SLOTS)
    ) dut (
        .CLK(CLK), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_slot(cmd_slot), .Min(Min),
        .row_valid(row_valid), .row_ready(row_ready), .row_in(row_in),
        .rd_slot(rd_slot), .rd_trans(rd_trans), .matrix(matrix),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [MW-1:0] m;
        bit            busy;
        bit            done;
    } exp_t;

    // Reference model: elements per slot, and the streamed rows collected so far.
    logic [EW-1:0] mem [SLOTS][ROWS][COLS];
    logic [RW-1:0] stageQ [$];
    bit            streaming = 1'b0;
    int            latched = 0;

    exp_t expQ [$];
    bit   errQ [$];
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [MW-1:0] viewSlot(input int s, input bit tr);
        logic [MW-1:0] v = '0;
        if (s >= SLOTS) return v;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (tr && TRANSPOSE) v[(c*ROWS + r)*EW +: EW] = mem[s][r][c];
                else                 v[(r*COLS + c)*EW +: EW] = mem[s][r][c];
            end
        end
        return v;
    endfunction

    task automatic storeSlot(input int s, input logic [MW-1:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[s][r][c] = v[(r*COLS + c)*EW +: EW];
    endtask

    task automatic modelReset();
        for (int s = 0; s < SLOTS; s++) storeSlot(s, '0);
        stageQ.delete();
        streaming = 1'b0;
        latched = 0;
    endtask

    // One clock of stimulus: drive after the sampling edge, then predict what the next sample must show.
    task automatic applyStimulus(input bit rstN, input bit cv, input logic [1:0] op, input int slot,
                                 input logic [MW-1:0] mIn, input bit rv, input logic [RW-1:0] row,
                                 input int rd, input bit tr);
        exp_t e;
        bit complete = 1'b0;
        bit errv = 1'b0;
        @(negedge CLK);
        #1;
        reset = rstN; cmd_valid = cv; cmd_op = op; cmd_slot = SW'(slot); Min = mIn;
        row_valid = rv; row_in = row; rd_slot = SW'(rd); rd_trans = tr;
        if (!rstN) begin
            modelReset();
            e.m = '0; e.busy = 1'b0; e.done = 1'b0;
            expQ.push_back(e);
            return;
        end
        e.m = viewSlot(rd, tr);
        if (!streaming) begin
            if (cv) begin
                complete = (op != OP_ROWLOAD) || (slot >= SLOTS);
                errv     = (op != OP_NOP) && (slot >= SLOTS);
                if (slot < SLOTS) begin
                    case (op)
                        OP_LOAD:    storeSlot(slot, mIn);
                        OP_CLEAR:   storeSlot(slot, '0);
                        OP_ROWLOAD: begin streaming = 1'b1; latched = slot; stageQ.delete(); end
                        default: ;
                    endcase
                end
            end
        end else if (rv) begin
            stageQ.push_back(row);
            if (stageQ.size() == ROWS) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        mem[latched][r][c] = stageQ[r][c*EW +: EW];
                stageQ.delete();
                streaming = 1'b0;
                complete = 1'b1;
            end
        end
        e.busy = streaming;
        e.done = complete;
        expQ.push_back(e);
        if (complete) errQ.push_back(errv);
    endtask

    task automatic cmdTick(input logic [1:0] op, input int slot, input logic [MW-1:0] mIn, input int rd);
        applyStimulus(1'b1, 1'b1, op, slot, mIn, 1'b0, '0, rd, 1'b0);
    endtask

    task automatic rowTick(input bit rv, input logic [RW-1:0] row, input int rd);
        applyStimulus(1'b1, 1'b0, OP_NOP, 0, '0, rv, row, rd, 1'b0);
    endtask

    task automatic idleTick(input int rd, input bit tr);
        applyStimulus(1'b1, 1'b0, OP_NOP, 0, '0, 1'b0, '0, rd, tr);
    endtask

    task automatic resetTick();
        applyStimulus(1'b0, 1'b0, OP_NOP, 0, '0, 1'b0, '0, 0, 1'b0);
    endtask

    function automatic logic [MW-1:0] randMatrix();
        logic [MW-1:0] v;
        for (int k = 0; k < ROWS*COLS; k++) v[k*EW +: EW] = $urandom;
        return v;
    endfunction

    function automatic logic [RW-1:0] randRow();
        logic [RW-1:0] v;
        for (int k = 0; k < COLS; k++) v[k*EW +: EW] = $urandom;
        return v;
    endfunction

    // Monitor: pops one prediction per sampled cycle; completion pulses also consume the err queue.
    initial begin
        exp_t e;
        bit   ee;
        forever begin
            @(negedge CLK);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("matrix", matrix, e.m);
                checkOutput("busy", MW'(busy), MW'(e.busy));
                checkOutput("row_ready", MW'(row_ready), MW'(e.busy));
                checkOutput("cmd_ready", MW'(cmd_ready), MW'(!e.busy));
                checkOutput("done", MW'(done), MW'(e.done));
                if (done) begin
                    if (errQ.size() > 0) begin
                        ee = errQ.pop_front();
                        checkOutput("err", MW'(err), MW'(ee));
                    end else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL done_unexpected actual=1 required=0");
                    end
                end else begin
                    checkOutput("err_without_done", MW'(err), '0);
                end
            end
        end
    end

    initial begin
        logic [MW-1:0] mk;
        logic [MW-1:0] m4;
        logic [MW-1:0] aa;
        logic [RW-1:0] row;
        int            guard;
        bit            rstN;
        logic [1:0]    op;
        int            slot;

        repeat (3) resetTick();

        // LOAD slot 2 with element k = k, then read every slot including the out-of-range one.
        for (int k = 0; k < ROWS*COLS; k++) mk[k*EW +: EW] = EW'(k);
        cmdTick(OP_LOAD, 2, mk, 2);
        idleTick(2, 1'b0);
        idleTick(0, 1'b0);
        idleTick(1, 1'b0);
        idleTick(3, 1'b0);

        // Streamed load with a stall after each beat; a command offered mid-stream must be ignored.
        cmdTick(OP_ROWLOAD, 1, '0, 1);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) row[c*EW +: EW] = EW'(32'h10*(r+1) + c);
            rowTick(1'b1, row, 1);
            if (r < ROWS-1) applyStimulus(1'b1, 1'b1, OP_LOAD, 1, randMatrix(), 1'b0, '0, 1, 1'b0);
        end
        idleTick(1, 1'b0);

        // Reset in the middle of a stream discards it; a following LOAD works.
        cmdTick(OP_ROWLOAD, 0, '0, 0);
        rowTick(1'b1, randRow(), 0);
        rowTick(1'b1, randRow(), 0);
        resetTick();
        cmdTick(OP_LOAD, 0, randMatrix(), 0);
        idleTick(0, 1'b0);
        idleTick(2, 1'b0);

        // Out-of-range target: LOAD, CLEAR and ROWLOAD all flag err and write nothing.
        cmdTick(OP_LOAD, 3, randMatrix(), 3);
        cmdTick(OP_CLEAR, 3, '0, 0);
        cmdTick(OP_ROWLOAD, 3, '0, 0);
        rowTick(1'b1, randRow(), 0);
        idleTick(3, 1'b0);

        // Read-during-write on the same slot.
        for (int k = 0; k < ROWS*COLS; k++) aa[k*EW +: EW] = 32'hAAAAAAAA;
        cmdTick(OP_LOAD, 0, aa, 0);
        cmdTick(OP_CLEAR, 0, '0, 0);
        idleTick(0, 1'b0);

        // Transposed and straight reads of element (r,c) = 4r+c.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m4[(r*COLS + c)*EW +: EW] = EW'(4*r + c);
        cmdTick(OP_LOAD, 1, m4, 1);
        idleTick(1, 1'b1);
        idleTick(1, 1'b0);
        idleTick(1, 1'b1);
        cmdTick(OP_NOP, 1, '0, 1);

        for (int i = 0; i < 600; i++) begin
            rstN = ($urandom_range(0, 99) != 0);
            op   = 2'($urandom_range(0, 3));
            slot = (op == OP_NOP) ? $urandom_range(0, SLOTS-1) : $urandom_range(0, 3);
            applyStimulus(rstN, 1'($urandom_range(0, 1)), op, slot, randMatrix(),
                          ($urandom_range(0, 3) != 0), randRow(), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
        end
        repeat (ROWS + 2) idleTick(1, 1'b0);

        guard = 0;
        while ((expQ.size() > 0) && (guard < 20)) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        checkOutput("exp_queue_drained", MW'(expQ.size()), '0);
        checkOutput("err_queue_drained", MW'(errQ.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
